// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and forwarding controller for a 5-stage RISC-V pipeline: load-use stalls,
// EX redirect flushes, EX operand forwarding, multicycle-EX freeze and perf counters.
module pipeline_hazard_ctrl #(
   parameter int REG_ADDR_W = 5,
   parameter int LOAD_STALL = 1,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_use_rs1,
   input  logic                  id_use_rs2,
   input  logic [REG_ADDR_W-1:0] ex_rs1,
   input  logic [REG_ADDR_W-1:0] ex_rs2,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_memread,
   input  logic                  ex_redirect,
   input  logic                  ex_mc_busy,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic                  mem_regwrite,
   input  logic                  wb_regwrite,
   input  logic                  perf_clr,
   output logic                  pc_write,
   output logic                  ifid_write,
   output logic                  idex_write,
   output logic                  idex_bubble,
   output logic                  exmem_bubble,
   output logic                  flush_if,
   output logic                  flush_id,
   output logic [1:0]            forward_a,
   output logic [1:0]            forward_b,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LD_STALL = 2'd1,
      MC_STALL = 2'd2
   } state_t;

   localparam logic [1:0]            LS_M1   = 2'(LOAD_STALL - 1);
   localparam logic [REG_ADDR_W-1:0] REG_X0  = {REG_ADDR_W{1'b0}};
   localparam logic [CNT_W-1:0]      CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t     state_r, state_nx_s;
   logic [1:0] remain_r, remain_nx_s;
   logic       lu_s, ld_active_s, redirect_acc_s;

   function automatic logic [1:0] fwd_sel(
      input logic [REG_ADDR_W-1:0] src,
      input logic [REG_ADDR_W-1:0] m_rd,
      input logic                  m_we,
      input logic [REG_ADDR_W-1:0] w_rd,
      input logic                  w_we
   );
      if (m_we && (m_rd != REG_X0) && (m_rd == src)) begin
         return 2'b10;
      end else if (w_we && (w_rd != REG_X0) && (w_rd == src)) begin
         return 2'b01;
      end else begin
         return 2'b00;
      end
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_ONE;
   endfunction

   assign lu_s = ex_memread && (ex_rd != REG_X0) &&
                 ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

   // A remaining load stall survives an MC freeze, so it is keyed on remain, not only on LD_STALL.
   assign ld_active_s = (state_r != RUN) && (remain_r != 2'd0);

   // Operand forwarding for the instruction in EX.
   always_comb begin
      forward_a = fwd_sel(ex_rs1, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
      forward_b = fwd_sel(ex_rs2, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
   end

   // Next-state and pipeline control, priority busy > redirect > load stall > run.
   always_comb begin
      pc_write       = 1'b1;
      ifid_write     = 1'b1;
      idex_write     = 1'b1;
      idex_bubble    = 1'b0;
      exmem_bubble   = 1'b0;
      flush_if       = 1'b0;
      flush_id       = 1'b0;
      state_nx_s     = state_r;
      remain_nx_s    = remain_r;
      redirect_acc_s = 1'b0;
      if (ex_mc_busy) begin
         pc_write     = 1'b0;
         ifid_write   = 1'b0;
         idex_write   = 1'b0;
         exmem_bubble = 1'b1;
         state_nx_s   = MC_STALL;
      end else if (ex_redirect) begin
         flush_if       = 1'b1;
         flush_id       = 1'b1;
         redirect_acc_s = 1'b1;
         state_nx_s     = RUN;
         remain_nx_s    = 2'd0;
      end else if (ld_active_s) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
         flush_id    = 1'b1;
         remain_nx_s = remain_r - 2'd1;
         state_nx_s  = (remain_r == 2'd1) ? RUN : LD_STALL;
      end else if (lu_s) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
         flush_id    = 1'b1;
         if (LS_M1 != 2'd0) begin
            state_nx_s  = LD_STALL;
            remain_nx_s = LS_M1;
         end else begin
            state_nx_s  = RUN;
            remain_nx_s = 2'd0;
         end
      end else begin
         state_nx_s  = RUN;
         remain_nx_s = 2'd0;
      end
   end

   // State and remaining-stall register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= RUN;
         remain_r <= 2'd0;
      end else begin
         state_r  <= state_nx_s;
         remain_r <= remain_nx_s;
      end
   end

   // Saturating performance counters; perf_clr wins over increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= {CNT_W{1'b0}};
         flush_cnt <= {CNT_W{1'b0}};
      end else if (perf_clr) begin
         stall_cnt <= {CNT_W{1'b0}};
         flush_cnt <= {CNT_W{1'b0}};
      end else begin
         if (!pc_write) begin
            stall_cnt <= sat_inc(stall_cnt);
         end
         if (redirect_acc_s) begin
            flush_cnt <= sat_inc(flush_cnt);
         end
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: two controller instances (LOAD_STALL=3/CNT_W=4 and LOAD_STALL=1/CNT_W=32)
// compared every cycle against a stall-debt reference model, plus directed scenario checks.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
   logic       id_use_rs1, id_use_rs2, ex_memread, ex_redirect, ex_mc_busy;
   logic       mem_regwrite, wb_regwrite, perf_clr;

   logic        pc_a, ifid_a, idex_a, idb_a, exb_a, fif_a, fid_a;
   logic [1:0]  fa_a, fb_a;
   logic [3:0]  scnt_a, fcnt_a;
   logic        pc_b, ifid_b, idex_b, idb_b, exb_b, fif_b, fid_b;
   logic [1:0]  fa_b, fb_b;
   logic [31:0] scnt_b, fcnt_b;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state, index 0 = instance a, 1 = instance b
   int     ls[2]   = '{3, 1};
   int     cw[2]   = '{4, 32};
   int     pend[2], pend_nx[2];
   longint scnt[2], fcnt[2];
   logic [6:0] exp_ctl[2];
   logic       exp_flush;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_STALL(3), .CNT_W(4)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_redirect(ex_redirect), .ex_mc_busy(ex_mc_busy),
      .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
      .perf_clr(perf_clr), .pc_write(pc_a), .ifid_write(ifid_a), .idex_write(idex_a),
      .idex_bubble(idb_a), .exmem_bubble(exb_a), .flush_if(fif_a), .flush_id(fid_a),
      .forward_a(fa_a), .forward_b(fb_a), .stall_cnt(scnt_a), .flush_cnt(fcnt_a));

   pipeline_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_STALL(1), .CNT_W(32)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_redirect(ex_redirect), .ex_mc_busy(ex_mc_busy),
      .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
      .perf_clr(perf_clr), .pc_write(pc_b), .ifid_write(ifid_b), .idex_write(idex_b),
      .idex_bubble(idb_b), .exmem_bubble(exb_b), .flush_if(fif_b), .flush_id(fid_b),
      .forward_a(fa_b), .forward_b(fb_b), .stall_cnt(scnt_b), .flush_cnt(fcnt_b));

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] ref_fwd(input logic [4:0] src);
      if (mem_regwrite && mem_rd != 5'd0 && mem_rd == src) return 2'b10;
      if (wb_regwrite && wb_rd != 5'd0 && wb_rd == src) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic ref_lu();
      return ex_memread && ex_rd != 5'd0 &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         pend[i] = 0;
         scnt[i] = 0;
         fcnt[i] = 0;
      end
   endtask

   // expected control vector order: pc, ifid, idex, idex_bubble, exmem_bubble, flush_if, flush_id
   task automatic eval_and_compare();
      exp_flush = ex_redirect && !ex_mc_busy;
      for (int i = 0; i < 2; i++) begin
         pend_nx[i] = pend[i];
         if (ex_mc_busy) begin
            exp_ctl[i] = 7'b0000100;
         end else if (ex_redirect) begin
            exp_ctl[i] = 7'b1110011;
            pend_nx[i] = 0;
         end else if (pend[i] > 0) begin
            exp_ctl[i] = 7'b0011001;
            pend_nx[i] = pend[i] - 1;
         end else if (ref_lu()) begin
            exp_ctl[i] = 7'b0011001;
            pend_nx[i] = ls[i] - 1;
         end else begin
            exp_ctl[i] = 7'b1110000;
         end
      end
      chk("a_ctl", 64'({pc_a, ifid_a, idex_a, idb_a, exb_a, fif_a, fid_a}), 64'(exp_ctl[0]));
      chk("b_ctl", 64'({pc_b, ifid_b, idex_b, idb_b, exb_b, fif_b, fid_b}), 64'(exp_ctl[1]));
      chk("a_fwd", 64'({fa_a, fb_a}), 64'({ref_fwd(ex_rs1), ref_fwd(ex_rs2)}));
      chk("b_fwd", 64'({fa_b, fb_b}), 64'({ref_fwd(ex_rs1), ref_fwd(ex_rs2)}));
      chk("a_stall_cnt", 64'(scnt_a), 64'(scnt[0]));
      chk("b_stall_cnt", 64'(scnt_b), 64'(scnt[1]));
      chk("a_flush_cnt", 64'(fcnt_a), 64'(fcnt[0]));
      chk("b_flush_cnt", 64'(fcnt_b), 64'(fcnt[1]));
   endtask

   task automatic model_commit();
      longint max_v;
      for (int i = 0; i < 2; i++) begin
         max_v = (64'sd1 <<< cw[i]) - 1;
         if (!rst_n) begin
            pend[i] = 0;
            scnt[i] = 0;
            fcnt[i] = 0;
         end else begin
            pend[i] = pend_nx[i];
            if (perf_clr) begin
               scnt[i] = 0;
               fcnt[i] = 0;
            end else begin
               if (!exp_ctl[i][6] && scnt[i] < max_v) scnt[i]++;
               if (exp_flush && fcnt[i] < max_v) fcnt[i]++;
            end
         end
      end
   endtask

   // inputs are set at the falling edge before calling this
   task automatic cycle();
      #1;
      eval_and_compare();
      @(posedge clk);
      model_commit();
      @(negedge clk);
   endtask

   task automatic idle();
      {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
      {id_use_rs1, id_use_rs2, ex_memread, ex_redirect, ex_mc_busy} = '0;
      {mem_regwrite, wb_regwrite, perf_clr} = '0;
   endtask

   task automatic clear_counters();
      idle();
      perf_clr = 1'b1;
      cycle();
      perf_clr = 1'b0;
   endtask

   task automatic load_use_x5();
      ex_memread = 1'b1;
      ex_rd      = 5'd5;
      id_rs2     = 5'd5;
      id_use_rs2 = 1'b1;
      cycle();
      ex_memread = 1'b0;
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      cycle();
      rst_n = 1'b1;
      cycle();

      // single / triple load-use stall
      clear_counters();
      load_use_x5();
      repeat (4) cycle();
      chk("a_ld3_stall", 64'(scnt_a), 64'd3);
      chk("b_ld1_stall", 64'(scnt_b), 64'd1);

      // load to x0 never stalls
      ex_memread = 1'b1;
      ex_rd      = 5'd0;
      id_rs2     = 5'd0;
      repeat (3) cycle();
      chk("a_x0_nostall", 64'(scnt_a), 64'd3);
      idle();

      // redirect in the second stall cycle aborts the load stall
      clear_counters();
      load_use_x5();
      ex_redirect = 1'b1;
      cycle();
      ex_redirect = 1'b0;
      repeat (3) cycle();
      chk("a_redir_stall", 64'(scnt_a), 64'd1);
      chk("a_redir_flush", 64'(fcnt_a), 64'd1);

      // MC freeze in the middle of a load stall, redirect during busy ignored
      clear_counters();
      load_use_x5();
      ex_mc_busy = 1'b1;
      cycle();
      ex_redirect = 1'b1;
      cycle();
      ex_redirect = 1'b0;
      repeat (2) cycle();
      ex_mc_busy = 1'b0;
      repeat (4) cycle();
      chk("a_mc_stall", 64'(scnt_a), 64'd7);
      chk("a_mc_flush", 64'(fcnt_a), 64'd0);

      // forwarding priority
      idle();
      ex_rs1 = 5'd7; mem_rd = 5'd7; wb_rd = 5'd7;
      mem_regwrite = 1'b1; wb_regwrite = 1'b1;
      #1 chk("fwd_exmem", 64'(fa_a), 64'd2);
      cycle();
      mem_regwrite = 1'b0;
      #1 chk("fwd_memwb", 64'(fa_a), 64'd1);
      cycle();
      mem_rd = 5'd0; wb_rd = 5'd0; mem_regwrite = 1'b1; wb_regwrite = 1'b1;
      #1 chk("fwd_x0", 64'(fa_a), 64'd0);
      cycle();

      // counter saturation and clear-over-increment
      clear_counters();
      ex_mc_busy = 1'b1;
      repeat (20) cycle();
      chk("a_sat", 64'(scnt_a), 64'd15);
      chk("b_nosat", 64'(scnt_b), 64'd20);
      perf_clr = 1'b1;
      cycle();
      chk("a_clr_prio", 64'(scnt_a), 64'd0);
      idle();

      // asynchronous reset in the middle of a load stall
      load_use_x5();
      cycle();
      rst_n = 1'b0;
      model_reset();
      #1 chk("a_rst_pc", 64'(pc_a), 64'd1);
      cycle();
      rst_n = 1'b1;
      cycle();

      // randomized traffic
      repeat (600) begin
         id_rs1       = 5'($urandom_range(0, 3));
         id_rs2       = 5'($urandom_range(0, 3));
         ex_rs1       = 5'($urandom_range(0, 3));
         ex_rs2       = 5'($urandom_range(0, 3));
         ex_rd        = 5'($urandom_range(0, 3));
         mem_rd       = 5'($urandom_range(0, 3));
         wb_rd        = 5'($urandom_range(0, 3));
         id_use_rs1   = 1'($urandom_range(0, 1));
         id_use_rs2   = 1'($urandom_range(0, 1));
         ex_memread   = 1'($urandom_range(0, 1));
         mem_regwrite = 1'($urandom_range(0, 1));
         wb_regwrite  = 1'($urandom_range(0, 1));
         ex_redirect  = ($urandom_range(0, 7) == 0);
         ex_mc_busy   = ($urandom_range(0, 9) == 0);
         perf_clr     = ($urandom_range(0, 49) == 0);
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
